// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port memory with MEM_LAT extra read wait cycles.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REQ0,
  input  logic          WE0,
  input  logic [AW-1:0] A0,
  input  logic [DW-1:0] WD0,
  output logic          GNT0,
  output logic          RVALID0,
  output logic [DW-1:0] RD0,
  input  logic          REQ1,
  input  logic          WE1,
  input  logic [AW-1:0] A1,
  input  logic [DW-1:0] WD1,
  output logic          GNT1,
  output logic          RVALID1,
  output logic [DW-1:0] RD1,
  output logic [AW-1:0] MEM_A,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WD,
  input  logic [DW-1:0] MEM_RD,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state;
  logic       owner;
  logic       we_q;
  logic [2:0] cnt;
  logic       winner;
  logic       finish;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic       last;
`endif

  always_comb begin
    winner = 1'b0;
    if (REQ0 && REQ1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last;
`endif
    end else if (REQ1) begin
      winner = 1'b1;
    end
  end

  // Read data is sampled at the end of the last cycle the address is presented.
  always_comb begin
    finish = 1'b0;
    if (state == ACCESS && MEM_LAT == 0) finish = 1'b1;
    if (state == WAIT && cnt == 3'd1)    finish = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= IDLE;
      owner   <= 1'b0;
      we_q    <= 1'b0;
      cnt     <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      RD0     <= '0;
      RD1     <= '0;
      MEM_A   <= '0;
      MEM_WE  <= 1'b0;
      MEM_WD  <= '0;
      BUSY    <= 1'b0;
    end else begin
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      RVALID0 <= 1'b0;
      RVALID1 <= 1'b0;
      MEM_WE  <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            owner  <= winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
            if (REQ0 && REQ1) last <= winner;
`endif
            MEM_A  <= winner ? A1 : A0;
            MEM_WD <= winner ? WD1 : WD0;
            MEM_WE <= winner ? WE1 : WE0;
            we_q   <= winner ? WE1 : WE0;
            GNT0   <= ~winner;
            GNT1   <= winner;
            BUSY   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (MEM_LAT == 0) begin
            state <= RESP;
          end else begin
            cnt   <= LAT;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        RVALID0 <= ~owner;
        RVALID1 <= owner;
        if (!we_q) begin
          if (owner) RD1 <= MEM_RD;
          else       RD0 <= MEM_RD;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for one single-port instruction/data memory (combinational or registered read, optional write).
- Accepts one transaction at a time from requester 0 (instruction fetch) or requester 1 (data/loader port).
- Drives the shared memory address/write lines for the programmed latency.
- Returns read data with a one-cycle completion pulse.
- Sits between the core's fetch/LSU paths and the memory block.

Parameters:
AW  32  address width of requester and memory address ports
DW  32  data width
MEM_LAT  0  memory read latency in extra wait cycles after the address cycle; legal range 0..7 (0 = combinational read)

Ports:
CLK  in  1  clock, all state updates on rising edge
RSTN  in  1  reset, synchronous, active-low
REQ0  in  1  requester 0 transaction request
WE0  in  1  requester 0 write enable (1 = write, 0 = read)
A0  in  AW  requester 0 address
WD0  in  DW  requester 0 write data
GNT0  out  1  requester 0 accept pulse
RVALID0  out  1  requester 0 completion pulse
RD0  out  DW  requester 0 read data
REQ1, WE1, A1, WD1, GNT1, RVALID1, RD1  same as requester 0, for requester 1
MEM_A  out  AW  memory address
MEM_WE  out  1  memory write strobe
MEM_WD  out  DW  memory write data
MEM_RD  in  DW  memory read data
BUSY  out  1  transaction in progress (state != IDLE)

Behaviour:
- All outputs are registered. Reset (RSTN=0 at edge) sets:
  - GNT0/1, RVALID0/1, MEM_WE, BUSY = 0
  - MEM_A, MEM_WD, RD0, RD1 = 0
  - state = IDLE, wait counter = 0, LAST = 1
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: REQx is sampled only here.
  - Winner: the sole requester if only one is active.
  - If both are active, winner = ~LAST (round-robin); LAST <= winner.
  - At the edge: latch owner, A, WE, WD into MEM_A/MEM_WE/MEM_WD; assert GNTwinner; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - GNTowner = 1 for this cycle only.
  - MEM_WE = latched WE for this cycle only.
  - If MEM_LAT = 0: capture MEM_RD into RDowner at the end of the cycle and go to RESP; else load counter = MEM_LAT and go to WAIT.
- WAIT:
  - MEM_A held, MEM_WE = 0, counter decrements each cycle.
  - When counter reaches 1: capture MEM_RD into RDowner (reads only), go to RESP.
- RESP (1 cycle): RVALIDowner = 1, then IDLE.
- Writes still pass through WAIT/RESP and pulse RVALID as a write ack; RDowner keeps its previous value.
- RDx holds its value until the next read completion for that requester.
- Latency: REQ seen in IDLE at cycle t → GNT at t+1 → RVALID at t+2+MEM_LAT → IDLE at t+3+MEM_LAT. Minimum 3 cycles per transaction.
- A requester must drop REQ the cycle after GNT unless it issues a new request. REQ still high when IDLE is re-entered is a new request.
- The non-owner's REQ is ignored while BUSY. Its GNT/RVALID stay 0.
- MEM_A and MEM_WD are stable from ACCESS through the last WAIT cycle. In IDLE they hold their last value.
- Reset mid-transaction: the transaction is aborted, with no GNT, RVALID, or write strobe after reset. The memory contents of an in-flight write are undefined only if the reset lands on the ACCESS cycle.
- Address and data pass through unmodified; no width conversion.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins when both request; LAST is not used.
- Undefined: round-robin as above.
- Everything else is identical in both cases.

Test Plan:
1. MEM_LAT=0, memory word 5 = 0xDEADBEEF, REQ0=1, A0=5, WE0=0 at t → GNT0 at t+1, RVALID0 at t+2, RD0=0xDEADBEEF; GNT1/RVALID1 stay 0.
2. Both REQ0 (A0=1) and REQ1 (A1=2) held high after reset → grant order 0,1,0,1 on successive transactions; RD0=mem[1], RD1=mem[2].
3. Write: REQ1=1, WE1=1, A1=8, WD1=0x12345678 → MEM_WE high exactly one cycle with MEM_A=8, MEM_WD=0x12345678; RVALID1 pulses; a following read via REQ0, A0=8 → RD0=0x12345678.
4. MEM_LAT=3, read at t → GNT at t+1, MEM_A stable t+1..t+4, RVALID at t+5, BUSY high t+1..t+5, next grant no earlier than t+7.
5. RSTN=0 during WAIT → next cycle all outputs 0 and no RVALID ever appears for that transaction. After release, both requesting → GNT0 first.
6. With MEM_ARB_FIXED_PRIO_EN defined, both held high for 4 transactions → GNT0 each time, GNT1 never. Then REQ0 dropped → GNT1 on the next transaction.
